// File: rtl/seq_mult_param_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_param_pkg;

  // Controller states: idle, one multiplier bit per cycle, result pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

  // Counter must hold 0..WIDTH so the final increment never wraps.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement magnitude. The most-negative value maps to
// 2^(WIDTH-1), which still fits when the result is read as unsigned.
module seq_mult_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             sgn_i,
  output logic [WIDTH-1:0] mag_o
);

  // Negate only for signed operands with the sign bit set.
  always_comb begin
    mag_o = val_i;
    if (sgn_i && val_i[WIDTH-1]) begin
      mag_o = -val_i;
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier, signed or unsigned per
// operation, one product per start with back-to-back restart from DONE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; d_out holds the previous product
// CALC    | one multiplier bit per cycle, LSB first, WIDTH cycles total
// DONE    | done_flag pulse; start here restarts without passing IDLE
module seq_mult_param
  import seq_mult_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] d_out,
  output logic               busy,
  output logic               done_flag
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     d_out_q, d_out_d;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [PW-1:0]     acc_sum;
  logic              last_step;
  logic              capture;

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i (a),
    .sgn_i (sgn),
    .mag_o (mag_a)
  );

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i (b),
    .sgn_i (sgn),
    .mag_o (mag_b)
  );

  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign capture   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state; busy and done are exclusive.
  always_comb begin
    busy      = (state_q == ST_CALC);
    done_flag = (state_q == ST_DONE);
    d_out     = d_out_q;
  end

  // Datapath next values: operand capture, shift-add step, final sign fix.
  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    d_out_d = d_out_q;
    acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
    if (state_q == ST_CALC) begin
      acc_d   = acc_sum;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      if (last_step) begin
        // acc_sum already includes this cycle's partial product.
        d_out_d = neg_q ? -acc_sum : acc_sum;
      end
    end else if (capture) begin
      mcand_d = {{WIDTH{1'b0}}, mag_a};
      mplr_d  = mag_b;
      acc_d   = '0;
      cnt_d   = '0;
      neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      d_out_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      d_out_q <= d_out_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param at WIDTH 8, 16 and 3 against an arithmetic model.
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start8 = 0, sgn8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] d8;
  logic        busy8, done8;

  logic        start16 = 0, sgn16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] d16;
  logic        busy16, done16;

  logic        start3 = 0, sgn3 = 0;
  logic [2:0]  a3 = 0, b3 = 0;
  logic [5:0]  d3;
  logic        busy3, done3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .d_out(d8), .busy(busy8), .done_flag(done8));

  seq_mult_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
    .d_out(d16), .busy(busy16), .done_flag(done16));

  seq_mult_param #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .sgn(sgn3), .a(a3), .b(b3),
    .d_out(d3), .busy(busy3), .done_flag(done3));

  // Reference: interpret operands as integers and multiply, wrap to 2*w bits.
  function automatic longint unsigned ref_prod(input int w, input longint unsigned av,
                                               input longint unsigned bv, input bit s);
    longint unsigned m;
    longint sa, sb;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'(av & m);
    sb = longint'(bv & m);
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    return longint'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // One WIDTH=8 operation; operands are scrambled while the DUT is busy.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input bit sv,
                        output logic [15:0] prod, output int lat,
                        output bit busy_ok, output bit stable_ok);
    logic [15:0] prev;
    @(negedge clk);
    prev = d8;
    a8 = av; b8 = bv; sgn8 = sv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    lat = 1; busy_ok = 1; stable_ok = 1;
    while (!done8 && lat < 40) begin
      if (!busy8) busy_ok = 0;
      if (d8 !== prev) stable_ok = 0;
      @(negedge clk);
      lat++;
      a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    end
    if (busy8) busy_ok = 0;
    prod = d8;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (d8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8: d_out=%h busy=%b done=%b, want 0/0/0", d8, busy8, done8);
    end
    total++;
    if (d16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0 ||
        d3 !== 6'h0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      bad++;
      $display("FAIL reset16_3: d16=%h d3=%h busy=%b%b done=%b%b, want zeros",
               d16, d3, busy16, busy3, done16, done3);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start: busy=%b done=%b, want 0/0", busy8, done8);
    end
  endtask

  task automatic test_unsigned;
    logic [7:0]  va [5] = '{8'h81, 8'hF0, 8'hFF, 8'hFF, 8'hAB};
    logic [7:0]  vb [5] = '{8'h13, 8'h35, 8'h00, 8'hF1, 8'hCD};
    logic [15:0] ve [5] = '{16'h0993, 16'h31B0, 16'h0000, 16'hF00F, 16'h88EF};
    logic [15:0] prod;
    int lat;
    bit bok, sok;
    for (int i = 0; i < 5; i++) begin
      do_op8(va[i], vb[i], 1'b0, prod, lat, bok, sok);
      total++;
      if (prod !== ve[i]) begin
        bad++;
        $display("FAIL unsigned_%0d: %h*%h got %h want %h", i, va[i], vb[i], prod, ve[i]);
      end
      total++;
      if (lat != 9) begin
        bad++;
        $display("FAIL latency_u%0d: got %0d cycles want 9", i, lat);
      end
      total++;
      if (!bok || !sok) begin
        bad++;
        $display("FAIL busy_stable_u%0d: busy_ok=%0d stable_ok=%0d want 1/1", i, bok, sok);
      end
    end
  endtask

  task automatic test_signed;
    logic [7:0]  va [4] = '{8'hFF, 8'h80, 8'h80, 8'h7F};
    logic [7:0]  vb [4] = '{8'hF1, 8'h80, 8'h01, 8'h81};
    logic [15:0] ve [4] = '{16'h000F, 16'h4000, 16'hFF80, 16'hC0FF};
    logic [15:0] prod;
    int lat;
    bit bok, sok;
    for (int i = 0; i < 4; i++) begin
      do_op8(va[i], vb[i], 1'b1, prod, lat, bok, sok);
      total++;
      if (prod !== ve[i]) begin
        bad++;
        $display("FAIL signed_%0d: %h*%h got %h want %h", i, va[i], vb[i], prod, ve[i]);
      end
      total++;
      if (lat != 9 || !bok || !sok) begin
        bad++;
        $display("FAIL timing_s%0d: lat=%0d busy_ok=%0d stable_ok=%0d want 9/1/1",
                 i, lat, bok, sok);
      end
    end
  endtask

  // start held high; operands change every 20 cycles regardless of phase.
  task automatic test_back_to_back;
    logic [7:0] qa[$], qb[$];
    bit qs[$];
    longint unsigned exp;
    int cyc, gap, got;
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom); start8 = 1'b1;
    qa.push_back(a8); qb.push_back(b8); qs.push_back(sgn8);
    cyc = 0; gap = 0; got = 0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++; gap++;
      if (cyc % 20 == 0) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      end
      if (done8) begin
        exp = ref_prod(8, qa.pop_front(), qb.pop_front(), qs.pop_front());
        total++;
        if (d8 !== exp[15:0]) begin
          bad++;
          $display("FAIL b2b_prod_%0d: got %h want %h", got, d8, exp[15:0]);
        end
        total++;
        if (gap != 9 || busy8 !== 1'b0) begin
          bad++;
          $display("FAIL b2b_gap_%0d: gap=%0d busy=%b want 9/0", got, gap, busy8);
        end
        gap = 0;
        got++;
        if (got < 10) begin
          qa.push_back(a8); qb.push_back(b8); qs.push_back(sgn8);
        end else begin
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    total++;
    if (got != 10) begin
      bad++;
      $display("FAIL b2b_count: got %0d products want 10", got);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [15:0] prod;
    int lat;
    bit bok, sok, saw_done;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (d8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: d_out=%h busy=%b done=%b want 0/0/0", d8, busy8, done8);
    end
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw_done = 1;
      if (busy8) saw_done = 1;
      rst = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL reset_abort: done/busy seen after reset, want none");
    end
    do_op8(8'h5A, 8'h3C, 1'b0, prod, lat, bok, sok);
    total++;
    if (prod !== 16'h1518 || lat != 9) begin
      bad++;
      $display("FAIL after_reset: got %h lat=%0d want 1518 lat=9", prod, lat);
    end
  endtask

  task automatic test_random16;
    logic [15:0] qa[$], qb[$];
    bit qs[$];
    longint unsigned exp;
    int cyc, gap, got;
    @(negedge clk);
    a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom); start16 = 1'b1;
    qa.push_back(a16); qb.push_back(b16); qs.push_back(sgn16);
    cyc = 0; gap = 0; got = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++; gap++;
      if (done16) begin
        exp = ref_prod(16, qa.pop_front(), qb.pop_front(), qs.pop_front());
        total++;
        if (d16 !== exp[31:0] || gap != 17) begin
          bad++;
          $display("FAIL rand16_%0d: got %h gap=%0d want %h gap=17", got, d16, gap, exp[31:0]);
        end
        gap = 0;
        got++;
        a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
        if (got < 1000) begin
          qa.push_back(a16); qb.push_back(b16); qs.push_back(sgn16);
        end else begin
          start16 = 1'b0;
        end
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
      end
    end
    start16 = 1'b0;
    total++;
    if (got != 1000) begin
      bad++;
      $display("FAIL rand16_count: got %0d products want 1000", got);
    end
  endtask

  task automatic test_random3;
    logic [2:0] qa[$], qb[$];
    bit qs[$];
    longint unsigned exp;
    int cyc, gap, got;
    @(negedge clk);
    a3 = 3'($urandom); b3 = 3'($urandom); sgn3 = 1'($urandom); start3 = 1'b1;
    qa.push_back(a3); qb.push_back(b3); qs.push_back(sgn3);
    cyc = 0; gap = 0; got = 0;
    while (got < 1000 && cyc < 6000) begin
      @(negedge clk);
      cyc++; gap++;
      if (done3) begin
        exp = ref_prod(3, qa.pop_front(), qb.pop_front(), qs.pop_front());
        total++;
        if (d3 !== exp[5:0] || gap != 4) begin
          bad++;
          $display("FAIL rand3_%0d: got %h gap=%0d want %h gap=4", got, d3, gap, exp[5:0]);
        end
        gap = 0;
        got++;
        a3 = 3'($urandom); b3 = 3'($urandom); sgn3 = 1'($urandom);
        if (got < 1000) begin
          qa.push_back(a3); qb.push_back(b3); qs.push_back(sgn3);
        end else begin
          start3 = 1'b0;
        end
      end else begin
        a3 = 3'($urandom); b3 = 3'($urandom); sgn3 = 1'($urandom);
      end
    end
    start3 = 1'b0;
    total++;
    if (got != 1000) begin
      bad++;
      $display("FAIL rand3_count: got %0d products want 1000", got);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    test_random3();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
